fetch_queue: RTL

//  Instruction fetch stage directly downstream of the PC stage.

---
 rtl/fetch_queue.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: issues ROM reads at the current PC and queues PC-tagged words toward decode.
// Define FETCH_PERF_EN to add saturating stall_cnt / flush_cnt performance counters.
module fetch_queue #(
    parameter int unsigned IW    = 9,
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc,
    output logic          pc_hold,
    output logic          imem_en,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_rdata,
    input  logic          flush,
    input  logic          halt,
    output logic [IW-1:0] inst,
    output logic [AW-1:0] inst_pc,
    output logic          inst_valid,
    input  logic          dec_ready,
    output logic          halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]   stall_cnt,
    output logic [7:0]    flush_cnt
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SQUASH = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          req_valid_q;
    logic [AW-1:0] req_pc_q;
    logic [AW-1:0] pc_mem_q  [DEPTH];
    logic [IW-1:0] ins_mem_q [DEPTH];

    logic issue;
    logic push;
    logic pop;

    // Credit check counts the in-flight word so a returning read always has a slot.
    assign issue = reset && (state_q == RUN) && !flush && !halt &&
                   ((count_q + CW'(req_valid_q)) < CW'(DEPTH));

    assign imem_en    = issue;
    assign imem_addr  = pc;
    assign pc_hold    = reset && !issue;
    assign inst_valid = (count_q != '0);
    assign inst       = ins_mem_q[rd_ptr_q];
    assign inst_pc    = pc_mem_q[rd_ptr_q];
    assign halted     = (state_q == HALTED);

    assign push = req_valid_q && !flush && (state_q == RUN);
    assign pop  = inst_valid && dec_ready && !flush;

    // Next-state: halt outranks flush; a flush drops queued and in-flight words.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        unique case (state_q)
            RUN: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (flush) begin
                    state_d = SQUASH;
                end
            end
            SQUASH:  state_d = halt ? HALTED : RUN;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase

        if (flush) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            req_valid_q <= 1'b0;
            req_pc_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]  <= '0;
                ins_mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            req_valid_q <= issue;
            if (issue) begin
                req_pc_q <= pc;
            end
            if (push) begin
                pc_mem_q[wr_ptr_q]  <= req_pc_q;
                ins_mem_q[wr_ptr_q] <= imem_rdata;
            end
        end
    end

    // A push into a full queue without a simultaneous pop would overwrite the head.
    no_overflow_a : assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && (count_q == CW'(DEPTH))));

`ifdef FETCH_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [7:0]  flush_cnt_q, flush_cnt_d;

    // Saturating counters: stalls are RUN cycles where the PC stage is held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((state_q == RUN) && pc_hold && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
